// File: rtl/conv2x2_seq_ctrl_pkg.sv
// Shared constants for the 2x2 dual-channel convolution sequencer.
// Holds the FSM state encoding, the weight address map and the datapath widths.
package conv2x2_seq_ctrl_pkg;

  localparam int unsigned PIX_W = 13;  // signed pixel width
  localparam int unsigned WGT_W = 8;   // signed weight width
  localparam int unsigned ACC_W = 22;  // signed per-tap datapath result width
  localparam int unsigned SUM_W = 24;  // signed 4-tap window sum width
  localparam int unsigned NUM_W = 8;   // weight registers (4 taps x 2 channels)

  localparam logic [0:0] ST_ACC = 1'b0;
  localparam logic [0:0] ST_OUT = 1'b1;

  localparam logic [2:0] WA0 = 3'd0;
  localparam logic [2:0] WA1 = 3'd1;
  localparam logic [2:0] WA2 = 3'd2;
  localparam logic [2:0] WA3 = 3'd3;
  localparam logic [2:0] WB0 = 3'd4;
  localparam logic [2:0] WB1 = 3'd5;
  localparam logic [2:0] WB2 = 3'd6;
  localparam logic [2:0] WB3 = 3'd7;

endpackage

// File: rtl/conv2x2_wreg.sv
// Weight register file: eight signed 8-bit weights written through a byte port.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   we_i         write strobe
//   addr_i       weight index (0-3 = WA0-WA3, 4-7 = WB0-WB3)
//   wdata_i      weight value
//   busy_i       window in progress; writes are rejected while high
//   weights_o    all weights, index i at bits [8*i +: 8]
//   cfg_err_o    one-cycle pulse after a rejected write
module conv2x2_wreg
  import conv2x2_seq_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   we_i,
  input  logic [2:0]             addr_i,
  input  logic [WGT_W-1:0]       wdata_i,
  input  logic                   busy_i,
  output logic [NUM_W*WGT_W-1:0] weights_o,
  output logic                   cfg_err_o
);

  logic [WGT_W-1:0] w_q [NUM_W];
  logic [WGT_W-1:0] w_d [NUM_W];
  logic             cfg_err_q, cfg_err_d;

  always_comb begin
    for (int i = 0; i < NUM_W; i++) begin
      w_d[i] = w_q[i];
    end
    if (we_i && !busy_i) begin
      w_d[addr_i] = wdata_i;
    end
    cfg_err_d = we_i & busy_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_W; i++) begin
        w_q[i] <= '0;
      end
      cfg_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_W; i++) begin
        w_q[i] <= w_d[i];
      end
      cfg_err_q <= cfg_err_d;
    end
  end

  for (genvar g = 0; g < NUM_W; g++) begin : g_wout
    assign weights_o[g*WGT_W +: WGT_W] = w_q[g];
  end

  assign cfg_err_o = cfg_err_q;

endmodule

// File: rtl/conv2x2_seq_ctrl.sv
// Sequencer for the 2x2 dual-channel convolution datapath. Owns the weights,
// steps the tap select across four accepted beats, accumulates the per-tap
// datapath results and presents the window sum (optional ReLU, saturation).
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   cfg_we/cfg_addr/cfg_wdata     weight write port; cfg_err flags rejected writes
//   flush                         abort the partial window (ignored while a result waits)
//   in_valid/in_ready/in_a/in_b   tap beat handshake and pixel pair
//   dp_a/dp_b/dp_sel/dp_wa*/dp_wb* drive the external datapath
//   dp_acc                        datapath result for the current tap
//   out_valid/out_ready/out_data  window result handshake
//   busy                          window in progress or result pending
module conv2x2_seq_ctrl
  import conv2x2_seq_ctrl_pkg::*;
#(
  parameter int unsigned OUT_W   = 24,
  parameter bit          RELU_EN = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [2:0]        cfg_addr,
  input  logic [WGT_W-1:0]  cfg_wdata,
  output logic              cfg_err,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PIX_W-1:0]  in_a,
  input  logic [PIX_W-1:0]  in_b,
  output logic [PIX_W-1:0]  dp_a,
  output logic [PIX_W-1:0]  dp_b,
  output logic [1:0]        dp_sel,
  output logic [WGT_W-1:0]  dp_wa0,
  output logic [WGT_W-1:0]  dp_wa1,
  output logic [WGT_W-1:0]  dp_wa2,
  output logic [WGT_W-1:0]  dp_wa3,
  output logic [WGT_W-1:0]  dp_wb0,
  output logic [WGT_W-1:0]  dp_wb1,
  output logic [WGT_W-1:0]  dp_wb2,
  output logic [WGT_W-1:0]  dp_wb3,
  input  logic [ACC_W-1:0]  dp_acc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              busy
);

  // Clamp bounds for OUT_W < SUM_W; at or above SUM_W they span the full sum range.
  localparam int unsigned      SatShift = (OUT_W < SUM_W) ? OUT_W - 1 : SUM_W - 1;
  localparam logic [SUM_W-1:0] SatMaxU  = (SUM_W'(1) << SatShift) - SUM_W'(1);
  localparam logic [SUM_W-1:0] SatMinU  = ~SatMaxU;

  logic [0:0]       state_q, state_d;
  logic [1:0]       tap_q, tap_d;
  logic [SUM_W-1:0] partial_q, partial_d;
  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;

  logic [NUM_W*WGT_W-1:0] weights;
  logic [SUM_W-1:0]       acc_ext;
  logic [SUM_W-1:0]       sum;
  logic signed [SUM_W-1:0] relu_v;
  logic signed [SUM_W-1:0] clip_v;

  assign busy = (tap_q != 2'd0) || (state_q == ST_OUT);

  conv2x2_wreg u_wreg (
    .clk       (clk),
    .rst_n     (rst_n),
    .we_i      (cfg_we),
    .addr_i    (cfg_addr),
    .wdata_i   (cfg_wdata),
    .busy_i    (busy),
    .weights_o (weights),
    .cfg_err_o (cfg_err)
  );

  assign dp_wa0 = weights[WA0*WGT_W +: WGT_W];
  assign dp_wa1 = weights[WA1*WGT_W +: WGT_W];
  assign dp_wa2 = weights[WA2*WGT_W +: WGT_W];
  assign dp_wa3 = weights[WA3*WGT_W +: WGT_W];
  assign dp_wb0 = weights[WB0*WGT_W +: WGT_W];
  assign dp_wb1 = weights[WB1*WGT_W +: WGT_W];
  assign dp_wb2 = weights[WB2*WGT_W +: WGT_W];
  assign dp_wb3 = weights[WB3*WGT_W +: WGT_W];

  assign dp_a   = in_a;
  assign dp_b   = in_b;
  assign dp_sel = tap_q;

  assign acc_ext = {{(SUM_W - ACC_W){dp_acc[ACC_W-1]}}, dp_acc};
  assign sum     = partial_q + acc_ext;

  // Window post-processing: ReLU first, then clamp into the signed OUT_W range.
  always_comb begin
    relu_v = signed'(sum);
    if (RELU_EN && relu_v[SUM_W-1]) begin
      relu_v = '0;
    end
    if (relu_v > signed'(SatMaxU)) begin
      clip_v = signed'(SatMaxU);
    end else if (relu_v < signed'(SatMinU)) begin
      clip_v = signed'(SatMinU);
    end else begin
      clip_v = relu_v;
    end
  end

  always_comb begin
    state_d     = state_q;
    tap_d       = tap_q;
    partial_d   = partial_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    unique case (state_q)
      ST_ACC: begin
        if (flush) begin
          // A beat in the same cycle as flush is dropped.
          tap_d     = 2'd0;
          partial_d = '0;
        end else if (in_valid) begin
          if (tap_q == 2'd3) begin
            out_data_d  = OUT_W'(clip_v);
            out_valid_d = 1'b1;
            partial_d   = '0;
            tap_d       = 2'd0;
            state_d     = ST_OUT;
          end else begin
            partial_d = sum;
            tap_d     = tap_q + 2'd1;
          end
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_ACC;
        end
      end
      default: state_d = ST_ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ACC;
      tap_q       <= 2'd0;
      partial_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      tap_q       <= tap_d;
      partial_q   <= partial_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign in_ready  = (state_q == ST_ACC);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_conv2x2_seq_ctrl.sv
// Directed bench for conv2x2_seq_ctrl. Two instances share the stimulus:
// u0 with defaults, u1 with RELU_EN=1. A small datapath model closes the loop
// from dp_* back to dp_acc for each instance.
module tb_conv2x2_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [7:0]  cfg_wdata;
  logic        flush;
  logic        in_valid;
  logic [12:0] in_a, in_b;
  logic        out_ready;

  logic        cfg_err0, in_ready0, out_valid0, busy0;
  logic [12:0] dp_a0, dp_b0;
  logic [1:0]  dp_sel0;
  logic [7:0]  wa00, wa10, wa20, wa30, wb00, wb10, wb20, wb30;
  logic [21:0] dp_acc0;
  logic [23:0] out_data0;

  logic        cfg_err1, in_ready1, out_valid1, busy1;
  logic [12:0] dp_a1, dp_b1;
  logic [1:0]  dp_sel1;
  logic [7:0]  wa01, wa11, wa21, wa31, wb01, wb11, wb21, wb31;
  logic [21:0] dp_acc1;
  logic [23:0] out_data1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  conv2x2_seq_ctrl #(.OUT_W(24), .RELU_EN(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_err(cfg_err0), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
    .in_a(in_a), .in_b(in_b), .dp_a(dp_a0), .dp_b(dp_b0), .dp_sel(dp_sel0),
    .dp_wa0(wa00), .dp_wa1(wa10), .dp_wa2(wa20), .dp_wa3(wa30),
    .dp_wb0(wb00), .dp_wb1(wb10), .dp_wb2(wb20), .dp_wb3(wb30),
    .dp_acc(dp_acc0), .out_valid(out_valid0), .out_ready(out_ready),
    .out_data(out_data0), .busy(busy0)
  );

  conv2x2_seq_ctrl #(.OUT_W(24), .RELU_EN(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_err(cfg_err1), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
    .in_a(in_a), .in_b(in_b), .dp_a(dp_a1), .dp_b(dp_b1), .dp_sel(dp_sel1),
    .dp_wa0(wa01), .dp_wa1(wa11), .dp_wa2(wa21), .dp_wa3(wa31),
    .dp_wb0(wb01), .dp_wb1(wb11), .dp_wb2(wb21), .dp_wb3(wb31),
    .dp_acc(dp_acc1), .out_valid(out_valid1), .out_ready(out_ready),
    .out_data(out_data1), .busy(busy1)
  );

  // Datapath model: a*WA[sel] + b*WB[sel], signed.
  function automatic logic [21:0] dpm(input logic [12:0] a, input logic [12:0] b,
                                      input logic [1:0] s,
                                      input logic [7:0] w0, input logic [7:0] w1,
                                      input logic [7:0] w2, input logic [7:0] w3,
                                      input logic [7:0] v0, input logic [7:0] v1,
                                      input logic [7:0] v2, input logic [7:0] v3);
    logic [7:0] wa, wb;
    logic signed [21:0] r;
    case (s)
      2'd0: begin wa = w0; wb = v0; end
      2'd1: begin wa = w1; wb = v1; end
      2'd2: begin wa = w2; wb = v2; end
      default: begin wa = w3; wb = v3; end
    endcase
    r = $signed(a) * $signed(wa) + $signed(b) * $signed(wb);
    return r;
  endfunction

  always_comb dp_acc0 = dpm(dp_a0, dp_b0, dp_sel0, wa00, wa10, wa20, wa30,
                            wb00, wb10, wb20, wb30);
  always_comb dp_acc1 = dpm(dp_a1, dp_b1, dp_sel1, wa01, wa11, wa21, wa31,
                            wb01, wb11, wb21, wb31);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; checks also run there.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] addr, input logic [7:0] data);
    cfg_we    = 1'b1;
    cfg_addr  = addr;
    cfg_wdata = data;
    cyc();
    cfg_we    = 1'b0;
  endtask

  task automatic beat(input logic [12:0] a, input logic [12:0] b);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    cyc();
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; flush = 1'b0;
    in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
    #12;
    chk("rst_out_valid", out_valid0, 0);
    chk("rst_out_data", out_data0, 0);
    chk("rst_cfg_err", cfg_err0, 0);
    chk("rst_in_ready", in_ready0, 1);
    chk("rst_busy", busy0, 0);
    chk("rst_dp_sel", dp_sel0, 0);
    chk("rst_wa0", wa00, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // Window 1: WA=1..4, WB=0, A=10..40 -> 300
    wr(3'd0, 8'd1); wr(3'd1, 8'd2); wr(3'd2, 8'd3); wr(3'd3, 8'd4);
    chk("w1_dp_wa3", wa30, 4);
    in_valid = 1'b1; in_b = '0;
    in_a = 13'd10; chk("w1_sel0", dp_sel0, 0); cyc();
    in_a = 13'd20; chk("w1_sel1", dp_sel0, 1); cyc();
    in_a = 13'd30; chk("w1_sel2", dp_sel0, 2); cyc();
    in_a = 13'd40; chk("w1_sel3", dp_sel0, 3);
    chk("w1_valid_before", out_valid0, 0);
    cyc();
    in_valid = 1'b0;
    chk("w1_valid", out_valid0, 1);
    chk("w1_data", out_data0, 300);
    chk("w1_in_ready_out", in_ready0, 0);
    chk("w1_busy_out", busy0, 1);
    cyc();
    chk("w1_valid_drop", out_valid0, 0);
    chk("w1_in_ready_back", in_ready0, 1);

    // Window 2: all weights -128, A=B=-4096 -> +4194304 without wrap
    for (int i = 0; i < 8; i++) wr(3'(i), 8'h80);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) beat(13'h1000, 13'h1000);
    chk("w2_valid", out_valid0, 1);
    chk("w2_data", out_data0, 24'h400000);
    chk("w2_relu_data", out_data1, 24'h400000);
    // Hold off the consumer for 3 cycles while a new beat is offered
    in_valid = 1'b1; in_a = 13'd7; in_b = 13'd0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("hold_data", out_data0, 24'h400000);
      chk("hold_valid", out_valid0, 1);
      chk("hold_in_ready", in_ready0, 0);
      chk("hold_sel", dp_sel0, 0);
      flush = (i == 1);  // ignored while the result is pending
    end
    flush = 1'b0;
    out_ready = 1'b1;
    cyc();
    chk("rel_valid", out_valid0, 0);
    chk("rel_in_ready", in_ready0, 1);
    chk("rel_sel", dp_sel0, 0);
    cyc();
    chk("rel_accept", dp_sel0, 1);
    in_valid = 1'b0;
    flush = 1'b1; cyc(); flush = 1'b0;
    chk("flush_sel", dp_sel0, 0);
    chk("flush_busy", busy0, 0);

    // Window 3: weights 127, A=B=-4096 -> negative; ReLU instance clamps to 0
    for (int i = 0; i < 8; i++) wr(3'(i), 8'd127);
    for (int i = 0; i < 4; i++) beat(13'h1000, 13'h1000);
    chk("w3_data", out_data0, 24'hC08000);
    chk("w3_relu_data", out_data1, 0);
    chk("w3_relu_valid", out_valid1, 1);
    cyc();

    // WA=1, WB=0 for the remaining windows
    for (int i = 0; i < 4; i++) wr(3'(i), 8'd1);
    for (int i = 4; i < 8; i++) wr(3'(i), 8'd0);

    // Config write while busy is rejected
    beat(13'd5, 13'd0); beat(13'd5, 13'd0);
    wr(3'd4, 8'h55);
    chk("busy_cfg_err", cfg_err0, 1);
    chk("busy_wb0", wb00, 0);
    cyc();
    chk("cfg_err_pulse_end", cfg_err0, 0);
    // Flush the 2-beat partial, then idle write lands
    flush = 1'b1; in_valid = 1'b1; in_a = 13'd100; cyc(); flush = 1'b0; in_valid = 1'b0;
    chk("flush2_sel", dp_sel0, 0);
    wr(3'd4, 8'h55);
    chk("idle_wb0", wb00, 8'h55);
    chk("idle_cfg_err", cfg_err0, 0);
    wr(3'd4, 8'h00);
    for (int i = 0; i < 4; i++) beat(13'd5, 13'd0);
    chk("flush_window", out_data0, 20);
    cyc();

    // Write to WA1 together with the first beat: applies from tap 1 -> 5+15+5+5
    cfg_we = 1'b1; cfg_addr = 3'd1; cfg_wdata = 8'd3;
    beat(13'd5, 13'd0);
    cfg_we = 1'b0;
    chk("coinc_cfg_err", cfg_err0, 0);
    for (int i = 0; i < 3; i++) beat(13'd5, 13'd0);
    chk("coinc_data", out_data0, 30);
    cyc();

    // Reset in the middle of a window
    beat(13'd5, 13'd0); beat(13'd5, 13'd0);
    chk("pre_rst_busy", busy0, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy0, 0);
    chk("mid_rst_sel", dp_sel0, 0);
    chk("mid_rst_in_ready", in_ready0, 1);
    chk("mid_rst_out_data", out_data0, 0);
    chk("mid_rst_wa1", wa10, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv2x2_seq_ctrl.md
Name: conv2x2_seq_ctrl

Overview:
Sequencer and weight-register owner for the combinational 2x2 dual-channel convolution datapath. Holds the eight signed 8-bit weights (A and B channels, taps 0..3) loaded through a byte-wide config port. Accepts one tap (A,B pixel pair) per handshake beat and steps the datapath tap select 0..3. Sums the four per-tap results into one window result, with optional ReLU, and presents it on a valid/ready output.

Parameters:
OUT_W, 24, output result width; the full 4-tap sum needs 24 bits; a smaller value saturates to the signed OUT_W range
RELU_EN, 0, 1 = clamp negative window results to 0 before output

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  reset, asynchronous assert, active-low
cfg_we  input  1  weight write strobe
cfg_addr  input  3  weight index: 0-3 = WA0-WA3, 4-7 = WB0-WB3
cfg_wdata  input  8  signed weight value
cfg_err  output  1  one-cycle pulse: write rejected because block busy
flush  input  1  synchronous abort of partial window
in_valid  input  1  tap beat valid
in_ready  output  1  tap beat accepted when in_valid&in_ready
in_a  input  13  signed channel-A pixel
in_b  input  13  signed channel-B pixel
dp_a  output  13  to datapath A (combinational = in_a)
dp_b  output  13  to datapath B (combinational = in_b)
dp_sel  output  2  to datapath tap select (= tap counter)
dp_wa0..dp_wa3  output  8 each  weight registers WA0-WA3
dp_wb0..dp_wb3  output  8 each  weight registers WB0-WB3
dp_acc  input  22  signed datapath result for current tap
out_valid  output  1  window result valid
out_ready  input  1  consumer accepts result
out_data  output  OUT_W  signed window result
busy  output  1  tap counter nonzero or ST_OUT

Behaviour:
- Reset values: state ST_ACC, tap=0, partial=0, all weights 0, out_valid=0, out_data=0, cfg_err=0, in_ready=1, busy=0.
- Reset mid-window discards partial sum and any pending result.
- ST_ACC: in_ready=1.
  - On a beat: partial += sign-extended dp_acc (24-bit accumulator); tap increments.
  - On the beat with tap==3: out_data <= post-processed (partial + dp_acc), out_valid<=1, partial<=0, tap<=0, next state ST_OUT.
- Result latency: 1 cycle after the 4th accepted beat.
- ST_OUT: in_ready=0. out_data and out_valid are held stable until out_ready, then out_valid<=0 and back to ST_ACC. in_ready returns to 1 the cycle after the handshake; no zero-bubble pass-through.
- Post-processing: apply RELU_EN (negative -> 0), then saturate to the OUT_W signed range (no-op at 24).
- dp_sel = tap in all states. dp_a and dp_b are pure wires from in_a and in_b.
- flush (ST_ACC): tap<=0, partial<=0; a beat coincident with flush is dropped. flush in ST_OUT is ignored; the pending result is not lost.
- Config writes:
  - Accepted only when busy==0; the weight updates next edge and is used from the next accepted beat.
  - A write with busy==1 leaves the weight unchanged and pulses cfg_err the next cycle.
  - A write coincident with the first beat of a window (busy==0) is accepted and affects tap 1 onward only if its index is ≥1; the spec fixes this, and the bench checks it.
- Arithmetic: two's complement throughout; 4 × (±2^21) fits 24-bit signed, so there is no internal overflow.

Decomposition:
- Shared package: state encoding ST_ACC/ST_OUT, weight address constants (WA0=0 … WB3=7), width constants PIX_W=13, WGT_W=8, ACC_W=22, SUM_W=24.
- One natural sub-module: conv2x2_wreg (8×8-bit weight file with busy-gated write and cfg_err).
- The datapath instance lives in the parent wrapper, not inside this block.

Test Plan:
- Weights WA=1,2,3,4, WB=0, A=10,20,30,40 back-to-back, out_ready=1 -> out_valid one cycle after 4th beat, out_data=300, dp_sel sequence 0,1,2,3.
- All WA=WB=-128, A=B=-4096 for 4 taps -> out_data=4194304, no wrap; same with WA=WB=127 and A=B=-4096 plus RELU_EN=1 -> out_data=0.
- Result pending with out_ready low 3 cycles -> out_data stable, in_ready=0, in_valid beats not consumed; out_ready high -> next window accepts from following cycle.
- Write cfg_addr=4 after 2 beats (busy) -> cfg_err pulse, WB0 unchanged; same write when idle -> dp_wb0 updates next cycle.
- flush after 2 beats then 4 new beats with WA=1, A=5 -> out_data=20 (partial discarded); rst_n low mid-window -> all outputs return to reset values immediately.
